// File: rtl/uart_transmitter.sv
// 8N1/8N2 UART serializer fed by the coordinator's transmit_byte/transmit_ready handshake.
// The line output is a flop; transmit_available is a decode of the idle state.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] transmit_byte,
  input  logic       transmit_ready,
  output logic       transmit_available,
  output logic       uart_tx
);

  localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [2:0]    DATA_LAST = 3'd7;
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_guard
      $error("uart_transmitter: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [1:0]    state_r;
  logic [BW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          uart_tx_r;
  logic          baud_done_s;

  assign baud_done_s        = (baud_cnt_r == BAUD_LAST);
  assign transmit_available = (state_r == IDLE);
  assign uart_tx            = uart_tx_r;

  // Frame sequencer: the line level for each bit is registered at the bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      uart_tx_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (transmit_ready) begin
            shift_r    <= transmit_byte;
            state_r    <= START;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            uart_tx_r  <= 1'b0;
          end else begin
            uart_tx_r  <= 1'b1;
          end
        end
        START: begin
          if (baud_done_s) begin
            state_r    <= DATA;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            uart_tx_r  <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_done_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == DATA_LAST) begin
              state_r   <= STOP;
              bit_cnt_r <= 3'd0;
              uart_tx_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              uart_tx_r <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_done_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == STOP_LAST) begin
              state_r   <= IDLE;
              bit_cnt_r <= 3'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= BAUD_ZERO;
          bit_cnt_r  <= 3'd0;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter: a frame-level line model plus a mid-bit
// receiver, run against a 1-stop-bit and a 2-stop-bit instance.
module tb_uart_transmitter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] transmit_byte;
  logic       ready_a, ready_b;
  logic       avail_a, avail_b;
  logic       tx_a, tx_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .transmit_byte(transmit_byte),
    .transmit_ready(ready_a), .transmit_available(avail_a), .uart_tx(tx_a)
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .transmit_byte(transmit_byte),
    .transmit_ready(ready_b), .transmit_available(avail_b), .uart_tx(tx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic avail_of(input int sel);
    return (sel != 0) ? avail_b : avail_a;
  endfunction

  task automatic set_ready(input int sel, input logic v);
    if (sel != 0) ready_b = v;
    else          ready_a = v;
  endtask

  task automatic idle_cycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx_of(sel)), 32'd1);
      check("idle_avail", 32'(avail_of(sel)), 32'd1);
    end
  endtask

  // Sends one byte and checks every cycle of the frame against the ideal line waveform.
  // inj_t > 0 pulses a competing 0xAA request during frame cycle inj_t.
  task automatic send(input int sel, input logic [7:0] b, input int inj_t);
    int   stops;
    int   len;
    logic frame[$];
    logic samples[64];
    logic [7:0] decoded;
    stops = (sel != 0) ? 2 : 1;
    len   = (9 + stops) * CPB;
    frame.delete();
    frame.push_back(1'b0);
    for (int k = 0; k < 8; k++) frame.push_back(b[k]);
    for (int s = 0; s < stops; s++) frame.push_back(1'b1);

    transmit_byte = b;
    set_ready(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ready(sel, 1'b0);
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      check("frame_tx", 32'(tx_of(sel)), 32'(frame[(t - 1) / CPB]));
      check("frame_avail", 32'(avail_of(sel)), 32'd0);
      samples[t] = tx_of(sel);
      if (t == inj_t) begin
        transmit_byte = 8'hAA;
        set_ready(sel, 1'b1);
      end else begin
        set_ready(sel, 1'b0);
      end
    end
    set_ready(sel, 1'b0);
    @(negedge clk);
    check("end_avail", 32'(avail_of(sel)), 32'd1);
    check("end_tx", 32'(tx_of(sel)), 32'd1);
    for (int k = 0; k < 8; k++) decoded[k] = samples[(k + 1) * CPB + CPB / 2];
    check("decoded_byte", 32'(decoded), 32'(b));
  endtask

  initial begin
    logic [7:0] rb;
    int sel, gap, inj, len;
    reset         = 1'b0;
    ready_a       = 1'b0;
    ready_b       = 1'b0;
    transmit_byte = 8'h00;
    #12;
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_avail_a", 32'(avail_a), 32'd1);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_avail_b", 32'(avail_b), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(0, 20);
    check("idle_tx_b", 32'(tx_b), 32'd1);

    send(0, 8'h55, 0);
    send(0, 8'h4C, 0);
    send(0, 8'h00, 0);
    send(0, 8'hFF, 0);
    send(0, 8'h8A, 0);
    send(0, 8'h52, 0);
    send(0, 8'h0F, 12);

    // Abort a frame during data bit 3, then confirm a clean restart.
    transmit_byte = 8'hC6;
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    for (int t = 1; t <= 4 * CPB + 2; t++) @(negedge clk);
    check("pre_abort_avail", 32'(avail_a), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_tx", 32'(tx_a), 32'd1);
    check("abort_avail", 32'(avail_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(0, 2);
    send(0, 8'h75, 0);

    send(1, 8'hC3, 0);
    send(1, 8'h5A, 20);

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      rb  = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      len = (sel != 0) ? 11 * CPB : 10 * CPB;
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
      idle_cycles(sel, gap);
      send(sel, rb, inj);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial byte transmitter directly downstream of the coordinator.
- Consumes the coordinator's transmit_byte/transmit_ready handshake, reports idle status back as transmit_available, and drives an 8N1 (configurable stop bits) UART line to the host.
- Replaces the delay-timer emulation used in coordinator simulation with the real serializer.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- transmit_byte  input  8  byte to send; sampled only on an accepted request
- transmit_ready  input  1  request strobe from the coordinator; single- or multi-cycle
- transmit_available  output  1  high when idle and able to accept a byte this cycle
- uart_tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, uart_tx=1, transmit_available=1.
  - Bit counter, baud counter and shift register cleared.
- transmit_available is high exactly when state==IDLE (combinational decode of the state register).
- Accept rule: transmit_ready && transmit_available at a rising edge latches transmit_byte into the shift register and moves the FSM to START.
  - transmit_available is low from the next cycle.
  - transmit_ready while transmit_available=0 is ignored; no queuing, and the latched byte is unchanged.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; the shift register shifts right at each bit boundary.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, is reset on entering each bit, and advances the bit index on terminal count.
  - Width is $clog2(CLKS_PER_BIT).
- Timing, with the accept edge at cycle A:
  - uart_tx falls at A+1.
  - Data bit k occupies cycles A+1+(k+1)*CLKS_PER_BIT .. A+(k+2)*CLKS_PER_BIT.
  - transmit_available returns high at A+1+(9+STOP_BITS)*CLKS_PER_BIT.
- Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles from the falling start edge to the next idle cycle.
- Back-to-back: a request accepted in the first cycle transmit_available is high starts the next start bit on the following cycle. No extra idle gap beyond the stop bit(s) is inserted.
- Reset mid-frame: the frame aborts immediately, uart_tx goes to 1 asynchronously, transmit_available=1. The partial byte is discarded.
- uart_tx is a flop output with no combinational path from inputs and no glitches.
- Byte value is transparent: 0x00 and 0xFF are transmitted like any other byte.
- Parameter guard: elaboration error if CLKS_PER_BIT<2 or STOP_BITS is not in {1,2}.

Test Plan:
- Reset, then idle for 20 cycles -> uart_tx=1 and transmit_available=1 throughout; the line never toggles.
- CLKS_PER_BIT=4, STOP_BITS=1, send 0x55 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; transmit_available low for exactly 40 cycles.
- Send ASCII "L" (0x4C) -> receiving bench model sampling mid-bit decodes 0x4C.
  - Repeat with 0x00 and 0xFF; both decode correctly.
- Two bytes 0x8A then 0x52, second ready asserted in the cycle transmit_available rises -> second start bit follows the first stop bit with zero gap; both decode correctly.
- Pulse transmit_ready with 0xAA while mid-frame of 0x0F -> 0xAA is ignored; decoded output is 0x0F only.
- Assert reset during data bit 3, then release and send 0x75 -> uart_tx=1 immediately at reset; after release only 0x75 is decoded.
- STOP_BITS=2 -> stop high lasts 8 cycles (CLKS_PER_BIT=4); frame length is 44 cycles.
